// File: rtl/qe_input_filter_pkg.sv
// ----------------------------------------------------------------------------
// qe_input_filter_pkg
// Shared constants and types for the quadrature-encoder input conditioning
// stage (qe_input_filter and its per-signal qe_bit_filter).
//   DEF_FILT_W    : default width of the stability counter / filter_len
//   DEF_ERR_CNT_W : default width of the saturating illegal-transition counter
//   filt_cnt_t    : stability counter type at default width
//   err_cnt_t     : illegal-transition counter type at default width
// ----------------------------------------------------------------------------
package qe_input_filter_pkg;

   localparam int DEF_FILT_W    = 8;
   localparam int DEF_ERR_CNT_W = 16;

   typedef logic [DEF_FILT_W-1:0]    filt_cnt_t;
   typedef logic [DEF_ERR_CNT_W-1:0] err_cnt_t;

endpackage

// File: rtl/qe_input_filter_bit_filter.sv
// ----------------------------------------------------------------------------
// qe_bit_filter
// Two-flop synchroniser followed by a stability filter for one encoder pin.
// The output only follows the synchronised input once it has differed from
// the output for filter_len+1 consecutive cycles; shorter excursions are
// dropped. With filter_enable low the synchronised value passes straight to
// the output register.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   async_in       : raw asynchronous pin
//   filter_enable  : 1 = filter active, 0 = bypass
//   filter_len     : required stable cycles minus 1
//   filt_out       : registered filtered value
//   next_out       : value filt_out takes on the next clock edge
// ----------------------------------------------------------------------------
module qe_bit_filter
   import qe_input_filter_pkg::*;
#(
   parameter int FILT_W = DEF_FILT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              async_in,
   input  logic              filter_enable,
   input  logic [FILT_W-1:0] filter_len,
   output logic              filt_out,
   output logic              next_out
);

   logic              sync_1;
   logic              sync_2;
   logic [FILT_W-1:0] stable_cnt;
   logic              differs;
   logic              fire;

   assign differs = (sync_2 != filt_out);
   // >= rather than == so that shrinking filter_len mid-count fires at once.
   assign fire    = differs && (stable_cnt >= filter_len);

   always_comb begin
      next_out = filt_out;
      if (!filter_enable) begin
         next_out = sync_2;
      end else if (fire) begin
         next_out = sync_2;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         stable_cnt <= '0;
         filt_out   <= 1'b0;
      end else begin
         sync_1   <= async_in;
         sync_2   <= sync_1;
         filt_out <= next_out;
         if (!filter_enable || !differs || fire) begin
            stable_cnt <= '0;
         end else if (stable_cnt != '1) begin
            // Saturate instead of wrapping so a long wait can never alias
            // back below filter_len.
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/qe_input_filter.sv
// ----------------------------------------------------------------------------
// qe_input_filter
// Conditioning stage ahead of a quadrature-encoder channel: synchronises and
// glitch-filters the A/B/I pins and flags illegal quadrature steps (A and B
// changing on the same edge). Illegal steps are still passed to the outputs.
// Optional feature macro: QE_ILLEGAL_DETECT_EN
//   defined   : illegal detection, err_flag and err_count are built
//   undefined : illegal_pulse/err_flag/err_count tied 0, clear_errors ignored
// Ports:
//   clk, reset               : clock, asynchronous active-low reset
//   async_QE_A/B/I           : raw encoder pins
//   filter_enable            : 1 = glitch filter active, 0 = bypass
//   filter_len               : required stable cycles minus 1
//   clear_errors             : 1-cycle strobe clearing err_count/err_flag
//   QE_A/B/I                 : filtered outputs
//   illegal_pulse            : 1-cycle pulse aligned with the illegal step
//   err_flag                 : sticky illegal-step flag
//   err_count                : saturating illegal-step count
// ----------------------------------------------------------------------------
module qe_input_filter
   import qe_input_filter_pkg::*;
#(
   parameter int FILT_W    = DEF_FILT_W,
   parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 async_QE_A,
   input  logic                 async_QE_B,
   input  logic                 async_QE_I,
   input  logic                 filter_enable,
   input  logic [FILT_W-1:0]    filter_len,
   input  logic                 clear_errors,
   output logic                 QE_A,
   output logic                 QE_B,
   output logic                 QE_I,
   output logic                 illegal_pulse,
   output logic                 err_flag,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic next_a;
   logic next_b;
   logic next_i;

   qe_bit_filter #(.FILT_W(FILT_W)) u_filt_a (
      .clk           (clk),
      .reset         (reset),
      .async_in      (async_QE_A),
      .filter_enable (filter_enable),
      .filter_len    (filter_len),
      .filt_out      (QE_A),
      .next_out      (next_a)
   );

   qe_bit_filter #(.FILT_W(FILT_W)) u_filt_b (
      .clk           (clk),
      .reset         (reset),
      .async_in      (async_QE_B),
      .filter_enable (filter_enable),
      .filter_len    (filter_len),
      .filt_out      (QE_B),
      .next_out      (next_b)
   );

   qe_bit_filter #(.FILT_W(FILT_W)) u_filt_i (
      .clk           (clk),
      .reset         (reset),
      .async_in      (async_QE_I),
      .filter_enable (filter_enable),
      .filter_len    (filter_len),
      .filt_out      (QE_I),
      .next_out      (next_i)
   );

   // The index look-ahead is not part of illegal detection.
   logic unused_ok;
   assign unused_ok = ^{next_i, next_a, next_b, clear_errors};

`ifdef QE_ILLEGAL_DETECT_EN
   logic illegal;

   // Both quadrature outputs are about to change on the same edge.
   assign illegal = (next_a != QE_A) && (next_b != QE_B);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         illegal_pulse <= 1'b0;
         err_flag      <= 1'b0;
         err_count     <= '0;
      end else begin
         illegal_pulse <= illegal;
         if (clear_errors) begin
            // A coincident event is counted after the clear, not lost.
            err_flag  <= illegal;
            err_count <= illegal ? ERR_CNT_W'(1) : '0;
         end else if (illegal) begin
            err_flag <= 1'b1;
            if (err_count != '1) begin
               err_count <= err_count + 1'b1;
            end
         end
      end
   end
`else
   assign illegal_pulse = 1'b0;
   assign err_flag      = 1'b0;
   assign err_count     = '0;
`endif

endmodule
